// File: rtl/svm_pkg.sv
// Shared definitions for the stage-1 SVM memory loader: default sizes, width helpers, loader state codes.
// Latency: none (package only).
// Backpressure: not applicable.
package svm_pkg;

  localparam int DEF_XLEN_PIXEL    = 8;
  localparam int DEF_NUM_OF_PIXELS = 4;
  localparam int DEF_NUM_OF_SV     = 10;

  // Select must also encode the test BRAM, which sits one past the last SV.
  function automatic int sel_w(input int num_sv);
    return $clog2(num_sv + 1);
  endfunction

  // Keep at least one bit so a single-pixel vector still has an address port.
  function automatic int pix_w(input int num_pix);
    return (num_pix > 1) ? $clog2(num_pix) : 1;
  endfunction

  typedef logic [1:0] ld_state_t;

  localparam ld_state_t ST_IDLE      = 2'd0;
  localparam ld_state_t ST_LOAD_SV   = 2'd1;
  localparam ld_state_t ST_LOAD_TEST = 2'd2;
  localparam ld_state_t ST_DONE      = 2'd3;

endpackage

// File: rtl/sv_mem_loader_if.sv
// Pixel stream in and BRAM write port out for the SVM memory loader.
// Latency: none (wiring only).
// Backpressure: s_ready from the loader stalls the stream; the write port has none.
interface sv_mem_loader_if
  import svm_pkg::*;
#(
  parameter int XLEN_PIXEL    = DEF_XLEN_PIXEL,
  parameter int NUM_OF_PIXELS = DEF_NUM_OF_PIXELS,
  parameter int NUM_OF_SV     = DEF_NUM_OF_SV
);

  localparam int SEL_W = sel_w(NUM_OF_SV);
  localparam int PIX_W = pix_w(NUM_OF_PIXELS);

  logic                  s_valid;
  logic [XLEN_PIXEL-1:0] s_data;
  logic                  s_last;
  logic                  s_ready;

  logic                  mem_we;
  logic [SEL_W-1:0]      mem_sel;
  logic [PIX_W-1:0]      mem_addr;
  logic [XLEN_PIXEL-1:0] mem_wdata;

  // Host / DMA side: produces the stream, observes the BRAM writes.
  modport master (
    output s_valid, s_data, s_last,
    input  s_ready,
    input  mem_we, mem_sel, mem_addr, mem_wdata
  );

  // Loader side: consumes the stream, drives the BRAM writes.
  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready,
    output mem_we, mem_sel, mem_addr, mem_wdata
  );

endinterface

// File: rtl/loader_beat_counter.sv
// Pixel / support-vector position counters for the loader, with end-of-vector and end-of-SV-set flags.
// Latency: counters advance on the edge that accepts a beat; flags are combinational from the counters.
// Backpressure: counters hold whenever adv is low (stalled stream).
module loader_beat_counter
  import svm_pkg::*;
#(
  parameter  int NUM_OF_PIXELS = DEF_NUM_OF_PIXELS,
  parameter  int NUM_OF_SV     = DEF_NUM_OF_SV,
  localparam int SEL_W         = sel_w(NUM_OF_SV),
  localparam int PIX_W         = pix_w(NUM_OF_PIXELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  output logic [PIX_W-1:0] pix,
  output logic [SEL_W-1:0] sv,
  output logic             last_beat,
  output logic             last_sv_beat
);

  assign last_beat    = (pix == PIX_W'(NUM_OF_PIXELS - 1));
  assign last_sv_beat = last_beat && (sv == SEL_W'(NUM_OF_SV - 1));

  // Pixel index wraps at the end of each vector and carries into the SV index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix <= '0;
      sv  <= '0;
    end else if (clr) begin
      pix <= '0;
      sv  <= '0;
    end else if (adv) begin
      if (last_beat) begin
        pix <= '0;
        sv  <= last_sv_beat ? '0 : sv + 1'b1;
      end else begin
        pix <= pix + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sv_mem_loader.sv
// Writes a framed pixel stream into the per-SV BRAMs and the test BRAM, then pulses stage1_en.
// Latency: one cycle from accepted beat to BRAM write; stage1_en two cycles after the final beat.
// Backpressure: s_ready is high only while loading; no internal buffering, one beat per cycle max.
module sv_mem_loader
  import svm_pkg::*;
#(
  parameter  int XLEN_PIXEL    = DEF_XLEN_PIXEL,
  parameter  int NUM_OF_PIXELS = DEF_NUM_OF_PIXELS,
  parameter  int NUM_OF_SV     = DEF_NUM_OF_SV,
  localparam int SEL_W         = sel_w(NUM_OF_SV),
  localparam int PIX_W         = pix_w(NUM_OF_PIXELS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            test_only,
  sv_mem_loader_if.slave  bus,
  output logic            busy,
  output logic            sv_loaded,
  output logic            stage1_en,
  output logic            err
);

  ld_state_t             state;
  logic                  beat;
  logic [XLEN_PIXEL-1:0] beat_dat;
  logic [PIX_W-1:0]      cnt_pix;
  logic [SEL_W-1:0]      cnt_sv;
  logic                  cnt_last_beat;
  logic                  cnt_last_sv_beat;

  assign bus.s_ready = (state == ST_LOAD_SV) || (state == ST_LOAD_TEST);
  assign beat        = bus.s_valid && bus.s_ready;
  assign beat_dat    = bus.s_data;
  assign busy        = (state != ST_IDLE);

  // Counters sit at zero in IDLE so every load starts at SV0 / pixel 0.
  loader_beat_counter #(
    .NUM_OF_PIXELS (NUM_OF_PIXELS),
    .NUM_OF_SV     (NUM_OF_SV)
  ) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .clr          (state == ST_IDLE),
    .adv          (beat),
    .pix          (cnt_pix),
    .sv           (cnt_sv),
    .last_beat    (cnt_last_beat),
    .last_sv_beat (cnt_last_sv_beat)
  );

  // Frame sequencing: s_last must land exactly on the final test pixel, otherwise abort with err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      sv_loaded <= 1'b0;
      stage1_en <= 1'b0;
      err       <= 1'b0;
    end else begin
      err       <= 1'b0;
      stage1_en <= (state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (!test_only)     state <= ST_LOAD_SV;
            else if (sv_loaded) state <= ST_LOAD_TEST;
            else                err   <= 1'b1;
          end
        end
        ST_LOAD_SV: begin
          if (beat) begin
            if (bus.s_last) begin
              // The frame cannot end inside the SV section; the SV set is now incomplete.
              err       <= 1'b1;
              sv_loaded <= 1'b0;
              state     <= ST_IDLE;
            end else if (cnt_last_sv_beat) begin
              sv_loaded <= 1'b1;
              state     <= ST_LOAD_TEST;
            end
          end
        end
        ST_LOAD_TEST: begin
          if (beat) begin
            if (cnt_last_beat != bus.s_last) begin
              err   <= 1'b1;
              state <= ST_IDLE;
            end else if (cnt_last_beat) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Registered BRAM write: every accepted beat is written, including the one that aborts a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_we    <= 1'b0;
      bus.mem_sel   <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_we <= beat;
      if (beat) begin
        bus.mem_sel   <= (state == ST_LOAD_TEST) ? SEL_W'(NUM_OF_SV) : cnt_sv;
        bus.mem_addr  <= cnt_pix;
        bus.mem_wdata <= beat_dat;
      end
    end
  end

endmodule

// File: tb/tb_sv_mem_loader.sv
// Scoreboard bench for sv_mem_loader: directed frames, expected writes queued, monitor compares.
// Latency: checks write one cycle after accept and stage1_en two cycles after the final beat.
// Backpressure: drives s_valid with and without idle gaps; waits on s_ready with a bound.
module tb_sv_mem_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic test_only = 1'b0;
  logic busy, sv_loaded, stage1_en, err;

  sv_mem_loader_if bus ();

  sv_mem_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .test_only (test_only),
    .bus       (bus.slave),
    .busy      (busy),
    .sv_loaded (sv_loaded),
    .stage1_en (stage1_en),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sel;
    logic [1:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_exp;
  int  checks = 0;
  int  failures = 0;
  int  stage1_cnt = 0;
  int  err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Expected write for beat b of a full frame: 4 pixels per SV, test vector at sel 10.
  task automatic push_beat(input int b);
    wr_t e;
    e.sel  = (b < 40) ? 4'(b / 4) : 4'd10;
    e.addr = 2'(b % 4);
    e.data = 8'(b);
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every write and counts pulse outputs.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: actual sel=%0d addr=%0d data=0x%0h required no write",
                   bus.mem_sel, bus.mem_addr, bus.mem_wdata);
        end else begin
          mon_exp = exp_q.pop_front();
          check("write", 32'({bus.mem_sel, bus.mem_addr, bus.mem_wdata}), 32'(mon_exp));
        end
      end
      if (stage1_en === 1'b1) stage1_cnt++;
      if (err === 1'b1) err_cnt++;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the start edge.
  task automatic do_start(input logic to);
    start = 1'b1;
    test_only = to;
    @(posedge clk);
    #1;
    start = 1'b0;
    test_only = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, input bit gaps);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 1)) begin
        bus.s_valid = 1'b0;
        start = ($urandom_range(0, 1) == 1);
        test_only = ($urandom_range(0, 1) == 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        test_only = 1'b0;
      end
    end
    bus.s_valid = 1'b1;
    bus.s_data = d;
    bus.s_last = last;
    n = 0;
    @(negedge clk);
    while (bus.s_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.s_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: actual s_ready=%b required 1 within 50 cycles", bus.s_ready);
    end
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
  endtask

  task automatic full_frame(input bit gaps);
    do_start(1'b0);
    for (int b = 0; b < 44; b++) begin
      push_beat(b);
      send_beat(8'(b), b == 43, gaps);
    end
  endtask

  // Final beat accepted at edge E: DONE after E, stage1_en only after E+1.
  task automatic check_frame_end(input string tag);
    @(negedge clk);
    check({tag, "_done_busy"}, 32'(busy), 32'd1);
    check({tag, "_early_stage1"}, 32'(stage1_en), 32'd0);
    @(negedge clk);
    check({tag, "_stage1"}, 32'(stage1_en), 32'd1);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_stage1_off"}, 32'(stage1_en), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 32'(bus.s_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    check({tag, "_mem_sel"}, 32'(bus.mem_sel), 32'd0);
    check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_sv_loaded"}, 32'(sv_loaded), 32'd0);
    check({tag, "_stage1_en"}, 32'(stage1_en), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL global_timeout: actual still running required finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = 8'h00;
    bus.s_last = 1'b0;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Test-only with no SV set loaded: err next cycle, never ready.
    do_start(1'b1);
    @(negedge clk);
    check("tonly_rst_err", 32'(err), 32'd1);
    check("tonly_rst_ready", 32'(bus.s_ready), 32'd0);
    @(negedge clk);
    check("tonly_rst_err_off", 32'(err), 32'd0);
    check("tonly_rst_ready2", 32'(bus.s_ready), 32'd0);
    @(posedge clk);
    #1;

    // Full frame at full rate, data = beat index.
    full_frame(1'b0);
    check_frame_end("full");
    check("full_sv_loaded", 32'(sv_loaded), 32'd1);

    // Test-only frame after a full load.
    do_start(1'b1);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(wr_t'{sel: 4'd10, addr: 2'(i), data: 8'(8'hA0 + i)});
      send_beat(8'(8'hA0 + i), i == 3, 1'b0);
    end
    check_frame_end("tonly");
    check("tonly_sv_loaded", 32'(sv_loaded), 32'd1);

    // s_last on beat 5: beat written at sel 1 addr 1, err, abort, SV set invalidated.
    do_start(1'b0);
    for (int b = 0; b < 6; b++) begin
      push_beat(b);
      send_beat(8'(b), b == 5, 1'b0);
    end
    @(negedge clk);
    check("early_err", 32'(err), 32'd1);
    check("early_busy", 32'(busy), 32'd0);
    check("early_sv_loaded", 32'(sv_loaded), 32'd0);
    check("early_ready", 32'(bus.s_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("early_no_stage1", 32'(stage1_cnt), 32'd2);
    @(posedge clk);
    #1;

    // Full frame with random idle gaps and stray start pulses.
    full_frame(1'b1);
    check_frame_end("gaps");
    check("gaps_sv_loaded", 32'(sv_loaded), 32'd1);

    // Reset during beat 20 of a full load.
    do_start(1'b0);
    for (int b = 0; b < 20; b++) begin
      push_beat(b);
      send_beat(8'(b), 1'b0, 1'b0);
    end
    bus.s_valid = 1'b1;
    bus.s_data = 8'd20;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    bus.s_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full load after the mid-frame reset.
    full_frame(1'b0);
    check_frame_end("post_rst");
    check("post_rst_sv_loaded", 32'(sv_loaded), 32'd1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("stage1_total", 32'(stage1_cnt), 32'd4);
    check("err_total", 32'(err_cnt), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
